// File: rtl/dmem_dual_issue_arb_pkg.sv
// Shared types for the dual-issue data-memory arbiter: FSM state encoding and the
// per-lane request bundle.
package dmem_dual_issue_arb_pkg;

    typedef enum logic {
        DMEM_ARB_IDLE   = 1'b0,
        DMEM_ARB_SECOND = 1'b1
    } dmem_arb_state_e;

    localparam int unsigned DMEM_REQ_WD = 70;

    typedef struct packed {
        logic        en;
        logic        wen;
        logic [3:0]  sel;
        logic [31:0] addr;
        logic [31:0] wdata;
    } dmem_req_t;

    // Byte write enables: a load drives no write strobes whatever its byte select.
    function automatic logic [3:0] req_wen(input dmem_req_t r);
        return r.sel & {4{r.wen}};
    endfunction

endpackage

// File: rtl/dmem_align_chk.sv
// Per-lane misalignment detector: halfword accesses must be 2-byte aligned, word accesses
// 4-byte aligned. Byte accesses never fault.
module dmem_align_chk (
    input  logic [3:0] sel,
    input  logic [1:0] addr,
    output logic       addr_err
);

    logic is_half;
    logic is_word;

    always_comb begin
        is_half  = ($countones(sel) == 2);
        is_word  = (sel == 4'hF);
        addr_err = (is_half & addr[0]) | (is_word & (addr != 2'b00));
    end

endmodule

// File: rtl/dmem_dual_issue_arb.sv
// Serialises the two issue lanes onto the single data SRAM port. Alignment checking is
// built in only when DMEM_ARB_ALIGN_CHECK_EN is defined.
module dmem_dual_issue_arb
    import dmem_dual_issue_arb_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        ex_go,
    input  logic        i1_en,
    input  logic        i2_en,
    input  logic        i1_wen,
    input  logic        i2_wen,
    input  logic [3:0]  i1_sel,
    input  logic [3:0]  i2_sel,
    input  logic [31:0] i1_addr,
    input  logic [31:0] i2_addr,
    input  logic [31:0] i1_wdata,
    input  logic [31:0] i2_wdata,
    input  logic        i1_except,
    input  logic [31:0] data_sram_rdata,
    output logic        data_sram_en,
    output logic [3:0]  data_sram_wen,
    output logic [31:0] data_sram_addr,
    output logic [31:0] data_sram_wdata,
    output logic        stallreq,
    output logic [31:0] rdata_i1,
    output logic [31:0] rdata_i2,
    output logic        addr_err_i1,
    output logic        addr_err_i2
);

    dmem_arb_state_e state_r;
    logic            ser_r;
    logic [31:0]     hold_r;

    dmem_req_t req1;
    dmem_req_t req2;
    dmem_req_t issue;
    logic      e1;
    logic      e2;

`ifdef DMEM_ARB_ALIGN_CHECK_EN
    dmem_align_chk u_align_i1 (
        .sel      (i1_sel),
        .addr     (i1_addr[1:0]),
        .addr_err (addr_err_i1)
    );

    dmem_align_chk u_align_i2 (
        .sel      (i2_sel),
        .addr     (i2_addr[1:0]),
        .addr_err (addr_err_i2)
    );
`else
    assign addr_err_i1 = 1'b0;
    assign addr_err_i2 = 1'b0;
`endif

    assign req1 = {i1_en, i1_wen, i1_sel, i1_addr, i1_wdata};
    assign req2 = {i2_en, i2_wen, i2_sel, i2_addr, i2_wdata};

    // A faulting lane 1 kills lane 2 as well so younger ops never touch memory.
    assign e1 = i1_en & ~addr_err_i1;
    assign e2 = i2_en & ~i1_except & ~addr_err_i1 & ~addr_err_i2;

    always_comb begin
        issue    = '0;
        stallreq = 1'b0;
        if (!(rst || flush)) begin
            unique case (state_r)
                DMEM_ARB_IDLE: begin
                    if (ex_go) begin
                        if (e1) begin
                            issue    = req1;
                            issue.en = 1'b1;
                        end else if (e2) begin
                            issue    = req2;
                            issue.en = 1'b1;
                        end
                        stallreq = e1 & e2;
                    end
                end
                DMEM_ARB_SECOND: begin
                    // EX is frozen this cycle, so lane 2's operands are still the pair's.
                    issue    = req2;
                    issue.en = 1'b1;
                end
            endcase
        end
    end

    assign data_sram_en    = issue.en;
    assign data_sram_wen   = req_wen(issue);
    assign data_sram_addr  = issue.addr;
    assign data_sram_wdata = issue.wdata;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            state_r <= DMEM_ARB_IDLE;
            ser_r   <= 1'b0;
            hold_r  <= '0;
        end else begin
            unique case (state_r)
                DMEM_ARB_IDLE: begin
                    if (ex_go) begin
                        if (e1 && e2) begin
                            state_r <= DMEM_ARB_SECOND;
                        end else begin
                            ser_r <= 1'b0;
                        end
                    end
                end
                DMEM_ARB_SECOND: begin
                    // Park lane 1's word so both lanes reach MEM together.
                    hold_r  <= data_sram_rdata;
                    ser_r   <= 1'b1;
                    state_r <= DMEM_ARB_IDLE;
                end
            endcase
        end
    end

    assign rdata_i1 = ser_r ? hold_r : data_sram_rdata;
    assign rdata_i2 = data_sram_rdata;

endmodule

// File: tb/tb_dmem_dual_issue_arb.sv
// Scoreboard bench for dmem_dual_issue_arb: program-order memory model predicts SRAM
// requests and per-lane MEM read data; a monitor pops and compares them.
module tb_dmem_dual_issue_arb;
    import dmem_dual_issue_arb_pkg::*;

`ifdef DMEM_ARB_ALIGN_CHECK_EN
    localparam bit ALIGN_ON = 1'b1;
`else
    localparam bit ALIGN_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        ex_go = 1'b0;
    logic        i1_en = 1'b0, i2_en = 1'b0, i1_wen = 1'b0, i2_wen = 1'b0;
    logic [3:0]  i1_sel = '0, i2_sel = '0;
    logic [31:0] i1_addr = '0, i2_addr = '0, i1_wdata = '0, i2_wdata = '0;
    logic        i1_except = 1'b0;
    logic [31:0] data_sram_rdata;
    logic        data_sram_en;
    logic [3:0]  data_sram_wen;
    logic [31:0] data_sram_addr, data_sram_wdata;
    logic        stallreq;
    logic [31:0] rdata_i1, rdata_i2;
    logic        addr_err_i1, addr_err_i2;

    dmem_dual_issue_arb dut (
        .clk             (clk),
        .rst             (rst),
        .flush           (flush),
        .ex_go           (ex_go),
        .i1_en           (i1_en),
        .i2_en           (i2_en),
        .i1_wen          (i1_wen),
        .i2_wen          (i2_wen),
        .i1_sel          (i1_sel),
        .i2_sel          (i2_sel),
        .i1_addr         (i1_addr),
        .i2_addr         (i2_addr),
        .i1_wdata        (i1_wdata),
        .i2_wdata        (i2_wdata),
        .i1_except       (i1_except),
        .data_sram_rdata (data_sram_rdata),
        .data_sram_en    (data_sram_en),
        .data_sram_wen   (data_sram_wen),
        .data_sram_addr  (data_sram_addr),
        .data_sram_wdata (data_sram_wdata),
        .stallreq        (stallreq),
        .rdata_i1        (rdata_i1),
        .rdata_i2        (rdata_i2),
        .addr_err_i1     (addr_err_i1),
        .addr_err_i2     (addr_err_i2)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit        en;
        bit        wen;
        bit [3:0]  sel;
        bit [31:0] addr;
        bit [31:0] wdata;
    } lane_t;

    typedef struct {
        int unsigned due;
        bit [3:0]    wen;
        bit [31:0]   addr;
        bit [31:0]   wdata;
    } req_exp_t;

    typedef struct {
        int unsigned due;
        bit          chk1;
        bit          chk2;
        bit [31:0]   v1;
        bit [31:0]   v2;
    } mem_exp_t;

    req_exp_t    rq[$];
    mem_exp_t    mq[$];
    bit [31:0]   sram [256];
    bit [31:0]   ref_mem [256];
    logic [31:0] sram_rdata = '0;
    int unsigned cyc = 0;
    int          n_chk = 0;
    int          n_pass = 0;

    assign data_sram_rdata = sram_rdata;

    // SRAM environment: one-cycle read latency, byte-masked writes.
    always @(posedge clk) begin
        if (data_sram_en) begin
            sram_rdata <= sram[data_sram_addr[9:2]];
            for (int b = 0; b < 4; b++)
                if (data_sram_wen[b])
                    sram[data_sram_addr[9:2]][b*8 +: 8] <= data_sram_wdata[b*8 +: 8];
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic bit align_err(input bit [3:0] sel, input bit [31:0] addr);
        return ALIGN_ON && ((($countones(sel) == 2) && addr[0]) ||
                            ((sel == 4'hF) && (addr[1:0] != 2'b00)));
    endfunction

    // Program-order reference: read the current word, then apply any store bytes.
    task automatic model_access(input lane_t l, output bit [31:0] rd);
        rd = ref_mem[l.addr[9:2]];
        if (l.wen)
            for (int b = 0; b < 4; b++)
                if (l.sel[b]) ref_mem[l.addr[9:2]][b*8 +: 8] = l.wdata[b*8 +: 8];
    endtask

    task automatic push_req(input lane_t l, input int unsigned due);
        req_exp_t r;
        r.due   = due;
        r.wen   = l.wen ? l.sel : 4'b0000;
        r.addr  = l.addr;
        r.wdata = l.wdata;
        rq.push_back(r);
    endtask

    task automatic drive(input lane_t a, input lane_t b, input bit exc, input bit go);
        i1_en = a.en;  i1_wen = a.wen;  i1_sel = a.sel;  i1_addr = a.addr;  i1_wdata = a.wdata;
        i2_en = b.en;  i2_wen = b.wen;  i2_sel = b.sel;  i2_addr = b.addr;  i2_wdata = b.wdata;
        i1_except = exc;
        ex_go     = go;
    endtask

    function automatic lane_t mk(input bit en, input bit wen, input bit [3:0] sel,
                                 input bit [31:0] addr, input bit [31:0] wdata);
        lane_t l;
        l.en = en; l.wen = wen; l.sel = sel; l.addr = addr; l.wdata = wdata;
        return l;
    endfunction

    function automatic lane_t rand_lane();
        lane_t   l;
        bit [1:0] off;
        bit [7:0] idx;
        int      sz;
        sz  = $urandom_range(0, 2);
        idx = 8'($urandom_range(0, 255));
        l.en    = ($urandom_range(0, 3) != 0);
        l.wen   = ($urandom_range(0, 2) == 0);
        l.wdata = $urandom;
        if (sz == 0) begin
            off   = 2'($urandom_range(0, 3));
            l.sel = 4'b0001 << off;
        end else if (sz == 1) begin
            off   = 2'($urandom_range(0, 1) * 2);
            l.sel = 4'b0011 << off;
        end else begin
            off   = 2'b00;
            l.sel = 4'hF;
        end
        l.addr = {22'd0, idx, off};
        return l;
    endfunction

    task automatic do_pair(input lane_t a, input lane_t b, input bit exc, input bit flush_sec);
        bit          err1, err2, e1, e2, dual;
        bit [31:0]   r1, r2;
        mem_exp_t    me;
        int unsigned t;
        @(posedge clk);
        #1;
        t = cyc;
        drive(a, b, exc, 1'b1);
        err1 = align_err(a.sel, a.addr);
        err2 = align_err(b.sel, b.addr);
        e1   = a.en && !err1;
        e2   = b.en && !exc && !err1 && !err2;
        dual = e1 && e2;
        me.chk1 = 1'b0; me.chk2 = 1'b0; me.v1 = '0; me.v2 = '0; me.due = 0;
        if (e1) begin
            push_req(a, t);
            model_access(a, r1);
            me.chk1 = !a.wen;
            me.v1   = r1;
        end
        if (e2 && !(dual && flush_sec)) begin
            push_req(b, dual ? t + 1 : t);
            model_access(b, r2);
            me.chk2 = !b.wen;
            me.v2   = r2;
        end
        @(negedge clk);
        check("stallreq", stallreq, dual);
        check("addr_err_i1", addr_err_i1, err1);
        check("addr_err_i2", addr_err_i2, err2);
        if (dual) begin
            @(posedge clk);
            #1;
            ex_go = 1'($urandom_range(0, 1));
            flush = flush_sec;
            @(negedge clk);
            check("stallreq_second", stallreq, 0);
        end
        if (dual && flush_sec) begin
            check("flush_no_issue", data_sram_en, 0);
            @(posedge clk);
            #1;
            flush = 1'b0;
            ex_go = 1'b0;
            check("flush_state", 32'(dut.state_r), 32'(DMEM_ARB_IDLE));
            check("flush_ser_r", dut.ser_r, 0);
            check("flush_hold_r", dut.hold_r, 0);
        end else if (e1 || e2) begin
            me.due = cyc + 1;
            mq.push_back(me);
        end
    endtask

    task automatic idle_cycle();
        @(posedge clk);
        #1;
        drive(rand_lane(), rand_lane(), 1'($urandom_range(0, 1)), 1'b0);
        @(negedge clk);
        check("idle_stallreq", stallreq, 0);
    endtask

    // Monitor: compares SRAM requests and MEM-stage read data against the scoreboard.
    always @(negedge clk) begin
        req_exp_t r;
        mem_exp_t m;
        if (rq.size() > 0 && rq[0].due == cyc) begin
            r = rq.pop_front();
            check("req_en", data_sram_en, 1);
            check("req_wen", data_sram_wen, r.wen);
            check("req_addr", data_sram_addr, r.addr);
            check("req_wdata", data_sram_wdata, r.wdata);
        end else if (data_sram_en) begin
            check("unexpected_req", data_sram_en, 0);
        end
        if (mq.size() > 0 && mq[0].due <= cyc) begin
            m = mq.pop_front();
            check("mem_due", cyc, m.due);
            if (m.chk1) check("rdata_i1", rdata_i1, m.v1);
            if (m.chk2) check("rdata_i2", rdata_i2, m.v2);
        end
    end

    initial begin
        lane_t none;
        lane_t a, b;
        int    k;
        none = mk(0, 0, 4'h0, 32'h0, 32'h0);
        for (int i = 0; i < 256; i++) begin
            sram[i]    = $urandom;
            ref_mem[i] = sram[i];
        end
        sram[32'h100 >> 2] = 32'hAABBCCDD;  ref_mem[32'h100 >> 2] = 32'hAABBCCDD;
        sram[32'h104 >> 2] = 32'h11223344;  ref_mem[32'h104 >> 2] = 32'h11223344;

        // Reset with a live dual request: nothing may reach the SRAM.
        drive(mk(1, 0, 4'hF, 32'h100, 0), mk(1, 0, 4'hF, 32'h104, 0), 1'b0, 1'b1);
        @(negedge clk);
        check("rst_stallreq", stallreq, 0);
        check("rst_sram_en", data_sram_en, 0);
        @(posedge clk);
        #1;
        rst   = 1'b0;
        ex_go = 1'b0;
        check("rst_state", 32'(dut.state_r), 32'(DMEM_ARB_IDLE));
        check("rst_ser_r", dut.ser_r, 0);
        check("rst_hold_r", dut.hold_r, 0);

        do_pair(mk(1, 0, 4'hF, 32'h100, 0), none, 1'b0, 1'b0);
        do_pair(mk(1, 0, 4'hF, 32'h100, 0), mk(1, 0, 4'hF, 32'h104, 0), 1'b0, 1'b0);
        do_pair(mk(1, 1, 4'h1, 32'h200, 32'h55), mk(1, 0, 4'h1, 32'h200, 0), 1'b0, 1'b0);
        do_pair(mk(1, 0, 4'hF, 32'h104, 0), mk(1, 0, 4'hF, 32'h100, 0), 1'b1, 1'b0);
        do_pair(mk(1, 0, 4'hF, 32'h100, 0), mk(1, 0, 4'hF, 32'h104, 0), 1'b0, 1'b1);
        do_pair(none, mk(1, 0, 4'hF, 32'h104, 0), 1'b0, 1'b0);
        do_pair(mk(1, 0, 4'hF, 32'h10C, 0), mk(1, 0, 4'hF, 32'h108, 0), 1'b0, 1'b0);
        do_pair(mk(1, 1, 4'hF, 32'h108, 32'hDEADBEEF), mk(1, 0, 4'hF, 32'h108, 0), 1'b0, 1'b0);
        if (ALIGN_ON)
            do_pair(mk(1, 0, 4'hF, 32'h102, 0), mk(1, 0, 4'hF, 32'h104, 0), 1'b0, 1'b0);
        idle_cycle();

        for (int n = 0; n < 400; n++) begin
            k = $urandom_range(0, 9);
            if (k == 0) begin
                idle_cycle();
            end else if (k == 1) begin
                a = rand_lane(); a.en = 1'b1;
                b = rand_lane(); b.en = 1'b1;
                do_pair(a, b, 1'b0, 1'b1);
            end else begin
                do_pair(rand_lane(), rand_lane(), ($urandom_range(0, 7) == 0), 1'b0);
            end
        end

        for (int n = 0; n < 4; n++) idle_cycle();
        check("req_queue_drained", rq.size(), 0);
        check("mem_queue_drained", mq.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
